mem_access_unit: RTL and testbench

- MEM-stage load/store unit between the EX/MEM pipeline register and the data memory.
- Checks alignment, generates byte enables and lane-replicated store data, and runs a req/ack handshake with a variable-latency data memory.
- Stalls the pipeline while a transaction is in flight.
- Returns the load word right-shifted so the addressed byte/half sits in bits [7:0]/[15:0], ready for the load sign/zero-extension mux.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/store_align.sv | 42 ++++
 rtl/mem_access_unit.sv | 154 +++++++++++++++
 tb/tb_mem_access_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared funct3, state and fault-code definitions for the MEM-stage load/store unit
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    FLT_NONE  = 2'b00,
    FLT_MISAL = 2'b01,
    FLT_TMO   = 2'b10,
    FLT_ILL   = 2'b11
  } fault_t;

endpackage

// File: rtl/store_align.sv
// rtl/store_align.sv - byte enables, lane-replicated store data and legality check for one access
module store_align
  import mem_pkg::*;
(
  input  logic        is_load,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic        illegal
);

  always_comb begin
    be         = 4'b1111;
    wdata      = data;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_B: begin
        be    = 4'b0001 << offset;
        wdata = {4{data[7:0]}};
      end
      F3_H: begin
        be         = 4'b0011 << offset;
        wdata      = {2{data[15:0]}};
        misaligned = offset[0];
      end
      F3_W:  misaligned = (offset != 2'b00);
      F3_BU: illegal = !is_load;
      F3_HU: begin
        illegal    = !is_load;
        misaligned = offset[0];
      end
      default: illegal = 1'b1;
    endcase
    // Loads always fetch the full word; lane selection happens on the way back.
    if (is_load) be = 4'b1111;
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with req/ack data-memory handshake and timeout
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_memRead,
  input  logic        ex_memWrite,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_storeData,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        lsu_stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic [2:0]  load_sel,
  output logic        lsu_fault,
  output logic [1:0]  fault_code
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit               TMO_EN   = (TIMEOUT != 0);

  state_t           state, state_next;
  fault_t           fault_next;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       offset;
  logic             is_read;
  logic             req_valid;
  logic             stall_comb;
  logic             capture, finish_ok, finish_tmo, report_fault;
  logic [3:0]       sa_be;
  logic [31:0]      sa_wdata;
  logic             sa_misal, sa_ill;

  assign req_valid = ex_valid & (ex_memRead | ex_memWrite);
  // Stall is the only combinational output; reset must still force it low.
  assign lsu_stall = rst_n & stall_comb;

  store_align u_store_align (
    .is_load    (ex_memRead),
    .funct3     (ex_funct3),
    .offset     (ex_addr[1:0]),
    .data       (ex_storeData),
    .be         (sa_be),
    .wdata      (sa_wdata),
    .misaligned (sa_misal),
    .illegal    (sa_ill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    stall_comb   = 1'b0;
    capture      = 1'b0;
    finish_ok    = 1'b0;
    finish_tmo   = 1'b0;
    report_fault = 1'b0;
    fault_next   = FLT_NONE;
    case (state)
      IDLE: begin
        if (req_valid) begin
          stall_comb = 1'b1;
          state_next = DONE;
          if (sa_ill) begin
            fault_next   = FLT_ILL;
            report_fault = 1'b1;
          end else if (sa_misal) begin
            fault_next   = FLT_MISAL;
            report_fault = 1'b1;
          end else begin
            capture    = 1'b1;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        stall_comb = 1'b1;
        if (dmem_ack) begin
          finish_ok  = 1'b1;
          state_next = DONE;
        end else if (TMO_EN && (cnt == TMO_LAST)) begin
          finish_tmo   = 1'b1;
          fault_next   = FLT_TMO;
          report_fault = 1'b1;
          state_next   = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      offset     <= 2'b00;
      is_read    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      load_valid <= 1'b0;
      load_data  <= '0;
      load_sel   <= '0;
      lsu_fault  <= 1'b0;
      fault_code <= FLT_NONE;
    end else begin
      load_valid <= 1'b0;
      lsu_fault  <= 1'b0;
      fault_code <= FLT_NONE;
      cnt        <= (state == BUSY) ? cnt + CNT_W'(1) : '0;
      if (capture) begin
        dmem_req   <= 1'b1;
        dmem_we    <= ~ex_memRead;
        dmem_addr  <= {ex_addr[31:2], 2'b00};
        dmem_be    <= sa_be;
        dmem_wdata <= ex_memRead ? 32'h0 : sa_wdata;
        load_sel   <= ex_funct3;
        offset     <= ex_addr[1:0];
        is_read    <= ex_memRead;
      end
      if (finish_ok) begin
        dmem_req   <= 1'b0;
        load_valid <= is_read;
        load_data  <= is_read ? (dmem_rdata >> {offset, 3'b000}) : 32'h0;
      end
      if (finish_tmo) begin
        dmem_req  <= 1'b0;
        load_data <= '0;
      end
      if (report_fault) begin
        lsu_fault  <= 1'b1;
        fault_code <= fault_next;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_memRead;
  logic        ex_memWrite;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_storeData;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        lsu_stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic [2:0]  load_sel;
  logic        lsu_fault;
  logic [1:0]  fault_code;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.TIMEOUT(4), .CNT_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_memRead   (ex_memRead),
    .ex_memWrite  (ex_memWrite),
    .ex_funct3    (ex_funct3),
    .ex_addr      (ex_addr),
    .ex_storeData (ex_storeData),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .lsu_stall    (lsu_stall),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_sel     (load_sel),
    .lsu_fault    (lsu_fault),
    .fault_code   (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    ex_valid     = 1'b1;
    ex_memRead   = rd;
    ex_memWrite  = wr;
    ex_funct3    = f3;
    ex_addr      = a;
    ex_storeData = d;
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid     = 1'b0;
    ex_memRead   = 1'b0;
    ex_memWrite  = 1'b0;
    ex_funct3    = 3'b000;
    ex_addr      = 32'h0;
    ex_storeData = 32'h0;
    dmem_ack     = 1'b0;
    dmem_rdata   = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dmem_req, dmem_we, dmem_be, lsu_stall, load_valid, lsu_fault, fault_code, load_sel} !== 14'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h want 0",
               {dmem_req, dmem_we, dmem_be, lsu_stall, load_valid, lsu_fault, fault_code, load_sel});
    end
    checks++;
    if ({dmem_addr, dmem_wdata, load_data} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {dmem_addr, dmem_wdata, load_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sw();
    int stall_cnt = 0;
    cyc();
    issue(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF);
    if (lsu_stall) stall_cnt++;
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL sw_req_in_request_cycle: got %b want 0", dmem_req);
    end
    cyc();
    if (lsu_stall) stall_cnt++;
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 1'b1, 32'h104, 4'b1111, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL sw_bus: got req=%b we=%b addr=%h be=%b wdata=%h want 1 1 00000104 1111 deadbeef",
               dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
    end
    cyc();
    dmem_ack = 1'b1;
    #1;
    if (lsu_stall) stall_cnt++;
    checks++;
    if ({dmem_req, dmem_be, dmem_wdata} !== {1'b1, 4'b1111, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL sw_bus_stable: got req=%b be=%b wdata=%h", dmem_req, dmem_be, dmem_wdata);
    end
    cyc();
    dmem_ack = 1'b0;
    #1;
    checks++;
    if (stall_cnt !== 3 || lsu_stall !== 1'b0) begin
      errors++;
      $display("FAIL sw_stall: got %0d cycles, done stall=%b want 3 cycles, 0", stall_cnt, lsu_stall);
    end
    checks++;
    if ({load_valid, lsu_fault, dmem_req} !== 3'b000) begin
      errors++;
      $display("FAIL sw_done: got lv=%b fault=%b req=%b want 000", load_valid, lsu_fault, dmem_req);
    end
    idle_inputs();
  endtask

  task automatic test_sb();
    cyc();
    issue(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5);
    cyc();
    checks++;
    if ({dmem_addr, dmem_be, dmem_wdata} !== {32'h100, 4'b1000, 32'hA5A5A5A5}) begin
      errors++;
      $display("FAIL sb_bus: got addr=%h be=%b wdata=%h want 00000100 1000 a5a5a5a5",
               dmem_addr, dmem_be, dmem_wdata);
    end
    dmem_ack = 1'b1;
    cyc();
    dmem_ack = 1'b0;
    checks++;
    if ({load_valid, lsu_fault} !== 2'b00) begin
      errors++;
      $display("FAIL sb_done: got lv=%b fault=%b want 00", load_valid, lsu_fault);
    end
    idle_inputs();
  endtask

  task automatic test_lh();
    cyc();
    issue(1'b1, 1'b0, 3'b001, 32'h202, 32'h0);
    cyc();
    checks++;
    if ({load_valid, dmem_we, dmem_be, dmem_addr} !== {1'b0, 1'b0, 4'b1111, 32'h200}) begin
      errors++;
      $display("FAIL lh_bus: got lv=%b we=%b be=%b addr=%h want 0 0 1111 00000200",
               load_valid, dmem_we, dmem_be, dmem_addr);
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h80011234;
    cyc();
    dmem_ack = 1'b0;
    checks++;
    if ({load_valid, load_data, load_sel} !== {1'b1, 32'h00008001, 3'b001}) begin
      errors++;
      $display("FAIL lh_load: got lv=%b data=%h sel=%b want 1 00008001 001", load_valid, load_data, load_sel);
    end
    idle_inputs();
    cyc();
    checks++;
    if (load_valid !== 1'b0) begin
      errors++;
      $display("FAIL lh_pulse: got %b want 0", load_valid);
    end
  endtask

  task automatic test_faults();
    logic        rd_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic        wr_t [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3_t [4] = '{3'b010, 3'b101, 3'b100, 3'b011};
    logic [31:0] ad_t [4] = '{32'h301, 32'h205, 32'h200, 32'h201};
    logic [1:0]  fc_t [4] = '{2'b01, 2'b01, 2'b11, 2'b11};
    for (int i = 0; i < 4; i++) begin
      cyc();
      issue(rd_t[i], wr_t[i], f3_t[i], ad_t[i], 32'h12345678);
      checks++;
      if ({lsu_stall, dmem_req} !== 2'b10) begin
        errors++;
        $display("FAIL fault%0d_request: got stall=%b req=%b want 1 0", i, lsu_stall, dmem_req);
      end
      cyc();
      checks++;
      if ({lsu_fault, fault_code, dmem_req, lsu_stall, load_valid} !== {1'b1, fc_t[i], 3'b000}) begin
        errors++;
        $display("FAIL fault%0d_done: got fault=%b code=%b req=%b stall=%b lv=%b want 1 %b 0 0 0",
                 i, lsu_fault, fault_code, dmem_req, lsu_stall, load_valid, fc_t[i]);
      end
      idle_inputs();
    end
    cyc();
    checks++;
    if ({lsu_fault, fault_code} !== 3'b000) begin
      errors++;
      $display("FAIL fault_pulse: got fault=%b code=%b want 0 00", lsu_fault, fault_code);
    end
  endtask

  task automatic test_timeout();
    int req_cnt = 0;
    cyc();
    issue(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (dmem_req) req_cnt++;
      else break;
    end
    checks++;
    if (req_cnt !== 4) begin
      errors++;
      $display("FAIL tmo_req_cycles: got %0d want 4", req_cnt);
    end
    checks++;
    if ({lsu_fault, fault_code, load_valid, load_data} !== {1'b1, 2'b10, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL tmo_done: got fault=%b code=%b lv=%b data=%h want 1 10 0 00000000",
               lsu_fault, fault_code, load_valid, load_data);
    end
    idle_inputs();
  endtask

  task automatic test_ack_at_timeout();
    cyc();
    issue(1'b1, 1'b1, 3'b010, 32'h400, 32'h55);
    cyc();
    checks++;
    if ({dmem_req, dmem_we} !== 2'b10) begin
      errors++;
      $display("FAIL rdwr_is_read: got req=%b we=%b want 1 0", dmem_req, dmem_we);
    end
    cyc();
    cyc();
    cyc();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h11223344;
    cyc();
    dmem_ack = 1'b0;
    checks++;
    if ({load_valid, lsu_fault, fault_code, load_data} !== {1'b1, 1'b0, 2'b00, 32'h11223344}) begin
      errors++;
      $display("FAIL ack_wins: got lv=%b fault=%b code=%b data=%h want 1 0 00 11223344",
               load_valid, lsu_fault, fault_code, load_data);
    end
    idle_inputs();
  endtask

  task automatic test_reset_busy();
    cyc();
    issue(1'b1, 1'b0, 3'b010, 32'h600, 32'h0);
    cyc();
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy_pre: got req=%b want 1", dmem_req);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dmem_req, lsu_stall, dmem_we, dmem_be, load_valid, lsu_fault, fault_code, dmem_addr, load_data} !== 75'h0) begin
      errors++;
      $display("FAIL rst_busy_async: got req=%b stall=%b be=%b addr=%h data=%h want all 0",
               dmem_req, lsu_stall, dmem_be, dmem_addr, load_data);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    issue(1'b1, 1'b0, 3'b100, 32'h3, 32'h0);
    cyc();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hF0000000;
    cyc();
    dmem_ack = 1'b0;
    checks++;
    if ({load_valid, load_data, load_sel} !== {1'b1, 32'h000000F0, 3'b100}) begin
      errors++;
      $display("FAIL lbu_after_reset: got lv=%b data=%h sel=%b want 1 000000f0 100", load_valid, load_data, load_sel);
    end
    idle_inputs();
    cyc();
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_lh();
    test_faults();
    test_timeout();
    test_ack_at_timeout();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
